// File: rtl/midi_tx.sv
// Serial MIDI note transmitter: one note event in, one 3-byte 8N1 message out (LSB first).
// Latency: tx start bit begins the cycle after accept; message is 30*CLKS_PER_BIT cycles, done one cycle later.
// Backpressure: eventReady only in IDLE; events offered while busy are not taken and must be held upstream.
module midi_tx #(
  parameter int          CLKS_PER_BIT = 3200,
  parameter logic [7:0]  NOTE_MIN     = 8'h28,
  parameter logic [7:0]  NOTE_MAX     = 8'h56
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       eventValid,
  output logic       eventReady,
  input  logic       noteOn,
  input  logic [3:0] channel,
  input  logic [6:0] note,
  input  logic [6:0] velocity,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       rangeErr
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, stateNext;
  logic [CW-1:0] baudCnt, baudNext;
  logic [2:0]    bitIdx, bitNext;
  logic [1:0]    byteIdx, byteNext;
  logic [7:0]    shiftReg, shiftNext;
  logic [7:0]    noteByte, velByte;
  logic          txReg, txNext;
  logic          doneReg, doneNext;
  logic          rangeErrReg, rangeErrNext;

  logic accept;
  logic inRange;
  logic bitEnd;

  assign eventReady = (state == IDLE) && !Reset;
  assign accept     = eventValid && eventReady;
  assign inRange    = ({1'b0, note} >= NOTE_MIN) && ({1'b0, note} <= NOTE_MAX);
  assign bitEnd     = (baudCnt == BAUD_LAST);

  assign tx       = txReg;
  assign busy     = (state != IDLE);
  assign done     = doneReg;
  assign rangeErr = rangeErrReg;

  // State, baud/bit/byte counters, shifter and registered line outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= IDLE;
      baudCnt     <= '0;
      bitIdx      <= '0;
      byteIdx     <= '0;
      shiftReg    <= '0;
      txReg       <= 1'b1;
      doneReg     <= 1'b0;
      rangeErrReg <= 1'b0;
    end else begin
      state       <= stateNext;
      baudCnt     <= baudNext;
      bitIdx      <= bitNext;
      byteIdx     <= byteNext;
      shiftReg    <= shiftNext;
      txReg       <= txNext;
      doneReg     <= doneNext;
      rangeErrReg <= rangeErrNext;
    end
  end

  // Hold the second and third bytes of an accepted event until they are shifted out
  always_ff @(posedge Clock) begin
    if (Reset) begin
      noteByte <= '0;
      velByte  <= '0;
    end else if (accept && inRange) begin
      noteByte <= {1'b0, note};
      velByte  <= {1'b0, velocity};
    end
  end

  // Next-state and next-output logic; txNext is the line level for the coming cycle
  always_comb begin
    stateNext    = state;
    baudNext     = baudCnt;
    bitNext      = bitIdx;
    byteNext     = byteIdx;
    shiftNext    = shiftReg;
    txNext       = 1'b1;
    doneNext     = 1'b0;
    rangeErrNext = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          if (inRange) begin
            stateNext = START;
            baudNext  = '0;
            bitNext   = '0;
            byteNext  = '0;
            shiftNext = {1'b1, 2'b00, noteOn, channel};
            txNext    = 1'b0;
          end else begin
            // Out-of-range note: consume the event, flag it, stay idle
            rangeErrNext = 1'b1;
          end
        end
      end

      START: begin
        txNext = 1'b0;
        if (bitEnd) begin
          baudNext  = '0;
          bitNext   = '0;
          stateNext = DATA;
          txNext    = shiftReg[0];
        end else begin
          baudNext = baudCnt + CW'(1);
        end
      end

      DATA: begin
        // shiftReg[0] is always the bit currently on the line
        txNext = shiftReg[0];
        if (bitEnd) begin
          baudNext = '0;
          if (bitIdx == 3'd7) begin
            stateNext = STOP;
            txNext    = 1'b1;
          end else begin
            shiftNext = {1'b0, shiftReg[7:1]};
            bitNext   = bitIdx + 3'd1;
            txNext    = shiftReg[1];
          end
        end else begin
          baudNext = baudCnt + CW'(1);
        end
      end

      STOP: begin
        txNext = 1'b1;
        if (bitEnd) begin
          baudNext = '0;
          if (byteIdx == 2'd2) begin
            stateNext = IDLE;
            doneNext  = 1'b1;
          end else begin
            // Next byte starts immediately: no idle time between bytes
            byteNext  = byteIdx + 2'd1;
            stateNext = START;
            shiftNext = (byteIdx == 2'd0) ? noteByte : velByte;
            txNext    = 1'b0;
          end
        end else begin
          baudNext = baudCnt + CW'(1);
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_midi_tx.sv
// Bench for midi_tx: directed and random note events, line checked cycle by cycle against expected frames.
// Expected line levels come from the message bytes built from event fields and the 8N1 bit layout.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_midi_tx;

  localparam int C = 4;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       eventValid = 1'b0;
  logic       eventReady;
  logic       noteOn = 1'b0;
  logic [3:0] channel = '0;
  logic [6:0] note = '0;
  logic [6:0] velocity = '0;
  logic       tx;
  logic       busy;
  logic       done;
  logic       rangeErr;

  int nAssert = 0;
  int nFail   = 0;

  midi_tx #(.CLKS_PER_BIT(C), .NOTE_MIN(8'h28), .NOTE_MAX(8'h56)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .eventValid (eventValid),
    .eventReady (eventReady),
    .noteOn     (noteOn),
    .channel    (channel),
    .note       (note),
    .velocity   (velocity),
    .tx         (tx),
    .busy       (busy),
    .done       (done),
    .rangeErr   (rangeErr)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [7:0] status_byte(input logic on, input logic [3:0] ch);
    return 8'h80 + (on ? 8'h10 : 8'h00) + {4'h0, ch};
  endfunction

  // Line level k cycles into a message: 3 frames of {start, 8 data LSB first, stop}, C cycles per bit
  function automatic logic exp_bit(input logic [7:0] b0, input logic [7:0] b1,
                                   input logic [7:0] b2, input int k);
    int pos;
    int w;
    logic [7:0] by;
    pos = k / C;
    w   = pos % 10;
    case (pos / 10)
      0:       by = b0;
      1:       by = b1;
      default: by = b2;
    endcase
    if (w == 0) return 1'b0;
    if (w == 9) return 1'b1;
    return by[w-1];
  endfunction

  task automatic offer(input logic on, input logic [3:0] ch, input logic [6:0] nt, input logic [6:0] vel);
    eventValid = 1'b1;
    noteOn     = on;
    channel    = ch;
    note       = nt;
    velocity   = vel;
  endtask

  // Called in the first cycle after accept; returns in the done cycle (or at abortK without stepping)
  task automatic check_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input int glitchK, input int abortK);
    for (int k = 0; k < 30*C; k++) begin
      if (k == abortK) return;
      if (k == glitchK) begin
        eventValid = 1'b1;
        noteOn     = ~noteOn;
        channel    = 4'($urandom);
        note       = 7'($urandom_range(8'h28, 8'h56));
        velocity   = 7'($urandom);
      end else begin
        eventValid = 1'b0;
        channel    = 4'($urandom);
        note       = 7'($urandom);
        velocity   = 7'($urandom);
      end
      chk("tx_bit", 32'(tx), 32'(exp_bit(b0, b1, b2, k)));
      chk("busy_in_msg", 32'(busy), 32'd1);
      chk("done_early", 32'(done), 32'd0);
      chk("ready_in_msg", 32'(eventReady), 32'd0);
      chk("rangeErr_in_msg", 32'(rangeErr), 32'd0);
      step();
    end
    eventValid = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
    chk("tx_idle_after", 32'(tx), 32'd1);
    chk("ready_at_done", 32'(eventReady), 32'd1);
  endtask

  task automatic send(input logic on, input logic [3:0] ch, input logic [6:0] nt, input logic [6:0] vel,
                      input int glitchK);
    offer(on, ch, nt, vel);
    chk("ready_before", 32'(eventReady), 32'd1);
    step();
    check_frame(status_byte(on, ch), {1'b0, nt}, {1'b0, vel}, glitchK, -1);
    step();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("tx_idle", 32'(tx), 32'd1);
  endtask

  task automatic range_case(input logic [6:0] nt);
    offer(1'b1, 4'h3, nt, 7'h40);
    step();
    eventValid = 1'b0;
    chk("rangeErr_pulse", 32'(rangeErr), 32'd1);
    chk("range_tx", 32'(tx), 32'd1);
    chk("range_busy", 32'(busy), 32'd0);
    chk("range_ready", 32'(eventReady), 32'd1);
    step();
    chk("rangeErr_clear", 32'(rangeErr), 32'd0);
    chk("range_tx2", 32'(tx), 32'd1);
    chk("range_busy2", 32'(busy), 32'd0);
  endtask

  initial begin
    logic       ron;
    logic [3:0] rch;
    logic [6:0] rnt;
    logic [6:0] rvel;

    // Reset state
    repeat (3) step();
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rangeErr", 32'(rangeErr), 32'd0);
    chk("rst_ready", 32'(eventReady), 32'd0);
    Reset = 1'b0;
    #1;
    chk("ready_after_rst", 32'(eventReady), 32'd1);

    // Directed messages
    send(1'b1, 4'h0, 7'h3C, 7'h64, -1);
    send(1'b0, 4'hF, 7'h28, 7'h00, -1);
    send(1'b1, 4'h5, 7'h56, 7'h00, -1);

    // Out-of-range notes on both sides
    range_case(7'h27);
    range_case(7'h57);

    // Held eventValid: second accept lands in the done cycle, no idle gap
    offer(1'b1, 4'h2, 7'h30, 7'h11);
    step();
    check_frame(status_byte(1'b1, 4'h2), 8'h30, 8'h11, -1, -1);
    offer(1'b0, 4'h9, 7'h50, 7'h7F);
    step();
    check_frame(status_byte(1'b0, 4'h9), 8'h50, 8'h7F, -1, -1);
    step();
    chk("b2b_done_clear", 32'(done), 32'd0);

    // Event pulsed mid-message is ignored and produces no extra message
    send(1'b1, 4'hA, 7'h45, 7'h22, 50);
    for (int i = 0; i < 3*C; i++) begin
      chk("no_extra_tx", 32'(tx), 32'd1);
      chk("no_extra_busy", 32'(busy), 32'd0);
      step();
    end

    // Reset in the middle of byte1 data bits
    offer(1'b1, 4'h7, 7'h33, 7'h55);
    step();
    check_frame(status_byte(1'b1, 4'h7), 8'h33, 8'h55, -1, 13*C);
    Reset = 1'b1;
    step();
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_ready", 32'(eventReady), 32'd0);
    Reset = 1'b0;
    #1;
    chk("midrst_ready_after", 32'(eventReady), 32'd1);
    for (int i = 0; i < 2*C; i++) begin
      step();
      chk("midrst_no_done", 32'(done), 32'd0);
      chk("midrst_idle_tx", 32'(tx), 32'd1);
    end
    send(1'b0, 4'h1, 7'h3F, 7'h01, -1);

    // Random events, some with out-of-range notes
    for (int i = 0; i < 8; i++) begin
      ron  = 1'($urandom);
      rch  = 4'($urandom);
      rvel = 7'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) rnt = 7'($urandom_range(0, 8'h27));
        else                           rnt = 7'($urandom_range(8'h57, 8'h7F));
        range_case(rnt);
      end else begin
        rnt = 7'($urandom_range(8'h28, 8'h56));
        send(ron, rch, rnt, rvel, -1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/midi_tx.md
Name: midi_tx

Overview:
- Serial MIDI transmitter: accepts one note event per handshake and emits a 3-byte channel voice message on a UART-style line (8N1, LSB first).
- Companion to the MIDI decode path. Events it accepts round-trip through the decoder: notes 0x28..0x56, velocity 0..127, note-on/off.
- Sits between the sequencer/control logic and the MIDI OUT pin.

Parameters:
- CLKS_PER_BIT, 3200, clock cycles per serial bit (100 MHz / 31250 baud); legal range >= 2.
- NOTE_MIN, 8'h28, lowest accepted note number.
- NOTE_MAX, 8'h56, highest accepted note number.

Ports:
- Clock  input  1  system clock; all logic on posedge.
- Reset  input  1  synchronous, active-high reset.
- eventValid  input  1  event offered this cycle.
- eventReady  output  1  transmitter can accept an event this cycle.
- noteOn  input  1  1 = Note On (status 0x9n), 0 = Note Off (status 0x8n).
- channel  input  4  MIDI channel n.
- note  input  7  note number.
- velocity  input  7  velocity.
- tx  output  1  serial line; idle high.
- busy  output  1  a message is being shifted out.
- done  output  1  one-cycle pulse when the last stop bit completes.
- rangeErr  output  1  one-cycle pulse when an event is rejected for note range.

Behaviour:
- Reset values: tx=1, eventReady=0 during the reset cycle, busy=0, done=0, rangeErr=0. State=IDLE; all counters and shift registers cleared.
- eventReady = (state==IDLE) && !Reset. Purely from registered state; no combinational path from eventValid.
- Accept happens when eventValid && eventReady on a clock edge. channel, noteOn, note and velocity are latched that edge. Later input changes are ignored.
- Range check on accept: if note < NOTE_MIN or note > NOTE_MAX:
  - the event is consumed but dropped;
  - rangeErr pulses the next cycle;
  - state stays IDLE and tx stays 1.
- Byte sequence for a valid event:
  - byte0 = {1'b1, 2'b00, noteOn, channel}, i.e. 0x80|ch or 0x90|ch;
  - byte1 = {1'b0, note};
  - byte2 = {1'b0, velocity}.
  - Note On with velocity 0 is sent unchanged (no conversion).
- FSM states: IDLE -> START -> DATA -> STOP -> (START if byteIdx<2, else IDLE).
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles; bitIdx counts 0..7.
  - STOP: tx=1 for CLKS_PER_BIT cycles; byteIdx increments.
- Timing:
  - tx is registered and goes low on the first cycle after the accept edge.
  - Bytes are back-to-back with no inter-byte idle.
  - Total message length = 30*CLKS_PER_BIT cycles.
- The baud counter counts 0..CLKS_PER_BIT-1 and wraps on each bit transition; there is no drift across bits.
- busy = 1 from the cycle after accept through the last STOP cycle inclusive.
- done pulses in the first IDLE cycle after the final STOP. eventReady is also 1 in that cycle, so back-to-back messages have zero idle gap when eventValid is held.
- No running status: every message carries a status byte.
- Reset mid-message: the next cycle has tx=1 and state IDLE. The partial frame is abandoned, no done pulse is issued, and eventReady=1 on the first cycle after Reset deasserts.
- eventValid while busy: ignored (eventReady=0); the upstream must hold it.

Test Plan:
- CLKS_PER_BIT=4; accept noteOn=1, ch=0, note=0x3C, vel=0x64 -> tx decodes to bytes 0x90,0x3C,0x64; each bit 4 cycles wide; done pulses exactly 120 cycles after the accept edge; busy high for 120 cycles.
- noteOn=0, ch=0xF, note=0x28, vel=0x00 -> bytes 0x8F,0x28,0x00. Loopback of each byte into the decoder (as MIDI_EVENT/MIDI_FREQ/MIDI_VEL) yields valid=1, type=0, delay=583, velocity=0.
- note=0x27, then note=0x57 -> rangeErr pulses once per event; tx stays 1; busy stays 0; eventReady stays 1 the following cycle.
- eventValid held high with two queued events -> second accept coincides with the done cycle; second start bit begins the next cycle, with no idle gap.
- Reset asserted during the DATA bits of byte1 -> next cycle tx=1, busy=0, no done; a new event afterwards transmits a correct full 3-byte message.
- eventValid pulsed mid-message with different fields -> ignored; the current message is unchanged and no extra message follows.
